gpio_spi_ctrl: RTL

GPIO_SPI_CTRL -- requirements
Module: gpio_spi_ctrl

---
 rtl/gpio_spi_pkg.sv | 29 ++
 rtl/gpio_reg_bank.sv | 51 +++++
 rtl/gpio_spi_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpio_spi_pkg.sv
// rtl/gpio_spi_pkg.sv - shared command layout, class codes and FSM encoding
package gpio_spi_pkg;

   // Command byte layout: W | class[2:0] | start index[3:0]
   localparam int CMD_W_BIT  = 7;
   localparam int CMD_CLS_HI = 6;
   localparam int CMD_CLS_LO = 4;
   localparam int CMD_IDX_HI = 3;
   localparam int CMD_IDX_LO = 0;

   localparam logic [2:0] CLS_OUT = 3'd0;
   localparam logic [2:0] CLS_DIR = 3'd1;
   localparam logic [2:0] CLS_IN  = 3'd2;

   localparam logic [7:0] ERR_FILL = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      XFER = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Burst index step with wrap back to port 0 after the last port
   function automatic logic [3:0] next_index(input logic [3:0] idx, input logic [4:0] num_ports);
      return ({1'b0, idx} + 5'd1 >= num_ports) ? 4'd0 : idx + 4'd1;
   endfunction

endpackage

// File: rtl/gpio_reg_bank.sv
// rtl/gpio_reg_bank.sv - GPIO output/direction registers and class/index read mux
module gpio_reg_bank
   import gpio_spi_pkg::*;
#(
   parameter int NUM_PORTS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2:0]             wr_cls,
   input  logic [3:0]             wr_idx,
   input  logic [7:0]             wr_data,
   input  logic                   we,
   input  logic [2:0]             rd_cls,
   input  logic [3:0]             rd_idx,
   output logic [7:0]             rd_data,
   input  logic [8*NUM_PORTS-1:0] gpio_in,
   output logic [8*NUM_PORTS-1:0] gpio_out,
   output logic [8*NUM_PORTS-1:0] gpio_dir
);

   // Single-port write into the addressed class; IN is read-only and never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_out <= '0;
         gpio_dir <= '0;
      end else if (we) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_idx == 4'(p)) begin
               if (wr_cls == CLS_OUT) gpio_out[8*p +: 8] <= wr_data;
               else if (wr_cls == CLS_DIR) gpio_dir[8*p +: 8] <= wr_data;
            end
         end
      end
   end

   // Read mux; IN returns the live synchronized pin sample
   always_comb begin
      rd_data = 8'h00;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rd_idx == 4'(p)) begin
            case (rd_cls)
               CLS_OUT: rd_data = gpio_out[8*p +: 8];
               CLS_DIR: rd_data = gpio_dir[8*p +: 8];
               CLS_IN:  rd_data = gpio_in[8*p +: 8];
               default: rd_data = 8'h00;
            endcase
         end
      end
   end

endmodule

// File: rtl/gpio_spi_ctrl.sv
// rtl/gpio_spi_ctrl.sv - SPI command decoder driving a bank of 8-bit GPIO ports
module gpio_spi_ctrl
   import gpio_spi_pkg::*;
#(
   parameter int NUM_PORTS = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   frame_active,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic [7:0]             tx_data,
   input  logic [8*NUM_PORTS-1:0] gpio_in,
   output logic [8*NUM_PORTS-1:0] gpio_out,
   output logic [8*NUM_PORTS-1:0] gpio_dir,
   output logic [7:0]             err_cnt
);

   localparam logic [4:0] NP = 5'(NUM_PORTS);

   state_t     state, state_nxt;
   logic       frame_prev;
   logic       frame_rise;
   logic [2:0] cls_q;
   logic       wr_q;
   logic [3:0] idx_q;
   logic       cmd_w;
   logic [2:0] cmd_cls;
   logic [3:0] cmd_idx;
   logic       cmd_ok;
   logic       cmd_byte;
   logic       data_byte;
   logic       we;
   logic [7:0] rd_data;

   assign cmd_w   = rx_data[CMD_W_BIT];
   assign cmd_cls = rx_data[CMD_CLS_HI:CMD_CLS_LO];
   assign cmd_idx = rx_data[CMD_IDX_HI:CMD_IDX_LO];
   assign cmd_ok  = (cmd_cls == CLS_OUT || cmd_cls == CLS_DIR || (cmd_cls == CLS_IN && !cmd_w))
                    && ({1'b0, cmd_idx} < NP);

   // frame_prev resets high so a frame already open at reset release is never decoded
   assign frame_rise = frame_active && !frame_prev;
   assign cmd_byte   = (state == CMD) && frame_active && rx_valid;
   assign data_byte  = (state == XFER) && frame_active && rx_valid;

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, write strobe and tx byte; frame end overrides everything
   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      tx_data   = 8'h00;
      if (!frame_active) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (frame_rise) state_nxt = CMD;
            CMD:     if (rx_valid) state_nxt = cmd_ok ? XFER : ERR;
            default: state_nxt = state;
         endcase
      end
      we = data_byte && wr_q;
      case (state)
         XFER:    tx_data = rd_data;
         ERR:     tx_data = ERR_FILL;
         default: tx_data = 8'h00;
      endcase
   end

   // Command capture, burst index walk and saturating error counter
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frame_prev <= 1'b1;
         cls_q      <= CLS_OUT;
         wr_q       <= 1'b0;
         idx_q      <= 4'd0;
         err_cnt    <= 8'h00;
      end else begin
         frame_prev <= frame_active;
         if (cmd_byte) begin
            if (cmd_ok) begin
               cls_q <= cmd_cls;
               wr_q  <= cmd_w;
               idx_q <= cmd_idx;
            end else if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else if (data_byte) begin
            idx_q <= next_index(idx_q, NP);
         end
      end
   end

   gpio_reg_bank #(.NUM_PORTS(NUM_PORTS)) u_bank (
      .clk      (CLK),
      .rst_n    (RST_N),
      .wr_cls   (cls_q),
      .wr_idx   (idx_q),
      .wr_data  (rx_data),
      .we       (we),
      .rd_cls   (cls_q),
      .rd_idx   (idx_q),
      .rd_data  (rd_data),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_dir (gpio_dir)
   );

endmodule
